// File: rtl/alu_op_sequencer_if.sv
// Command/response channel bundle between the control path and the ALU op sequencer.
//   master : control path (drives cmd_*, rsp_ready; observes cmd_ready, rsp_*)
//   slave  : alu_op_sequencer (accepts commands, returns responses)
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [5:0] rsp_data;
  logic       rsp_is_logic;
  logic       rsp_ovf;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_is_logic, rsp_ovf
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_is_logic, rsp_ovf
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the 4-bit combinational ALU. Takes one operation at a
// time, holds the ALU inputs in registers for SETTLE_CYCLES edges, captures the
// arithmetic or logic result and returns it with an overflow flag.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   bus (slave)        cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_sel,
//                      rsp_valid/rsp_ready/rsp_data/rsp_is_logic/rsp_ovf
//   alu_a/alu_b/alu_sel registered ALU operands and op select
//   alu_y_a, alu_y_l   ALU arithmetic (6-bit signed) and logic (4-bit) results
//   op_count           completed responses, wraps modulo 2^CNT_W
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_op_sequencer_if.slave        bus,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [3:0]               alu_sel,
  input  logic [5:0]               alu_y_a,
  input  logic [3:0]               alu_y_l,
  output logic [CNT_W-1:0]         op_count
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [3:0]         alu_a_q, alu_a_d;
  logic [3:0]         alu_b_q, alu_b_d;
  logic [3:0]         alu_sel_q, alu_sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [5:0]         rsp_data_q, rsp_data_d;
  logic               rsp_is_logic_q, rsp_is_logic_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  // Result fits -8..+7 only when the top three bits are a pure sign extension.
  logic arith_ovf_c;
  assign arith_ovf_c = !((alu_y_a[5:3] == 3'b000) || (alu_y_a[5:3] == 3'b111));

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cmd_ready_d    = cmd_ready_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_sel_d      = alu_sel_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_is_logic_d = rsp_is_logic_q;
    rsp_ovf_d      = rsp_ovf_q;
    op_count_d     = op_count_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          alu_a_d     = bus.cmd_a;
          alu_b_d     = bus.cmd_b;
          alu_sel_d   = bus.cmd_sel;
          cnt_d       = SET_LOAD;
          cmd_ready_d = 1'b0;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          if (alu_sel_q[3]) begin
            rsp_data_d     = {2'b00, alu_y_l};
            rsp_is_logic_d = 1'b1;
            rsp_ovf_d      = 1'b0;
          end else begin
            rsp_data_d     = alu_y_a;
            rsp_is_logic_d = 1'b0;
            rsp_ovf_d      = arith_ovf_c;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - SET_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      cmd_ready_q    <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_sel_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_is_logic_q <= 1'b0;
      rsp_ovf_q      <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_sel_q      <= alu_sel_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_is_logic_q <= rsp_is_logic_d;
      rsp_ovf_q      <= rsp_ovf_d;
      op_count_q     <= op_count_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_is_logic = rsp_is_logic_q;
  assign bus.rsp_ovf      = rsp_ovf_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_sel          = alu_sel_q;
  assign op_count         = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (settle 1 and settle 3), each fed by a
// behavioural 4-bit ALU. Expected responses are queued when a command is driven and
// popped when the response appears.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [5:0] data;
    logic       is_logic;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst3_n;

  int   n_cmp;
  int   n_err;
  int   cyc;
  logic [7:0] cnt1;
  exp_t exp_q[$];

  alu_op_sequencer_if bus1 ();
  alu_op_sequencer_if bus3 ();

  logic [3:0] alu1_a, alu1_b, alu1_sel, alu1_y_l;
  logic [5:0] alu1_y_a;
  logic [7:0] op1_count;
  logic [3:0] alu3_a, alu3_b, alu3_sel, alu3_y_l;
  logic [5:0] alu3_y_a;
  logic [7:0] op3_count;

  // Behavioural ALU: 0xxx arithmetic (6-bit signed), 1xxx logic.
  function automatic logic [5:0] alu_arith(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] sel);
    logic signed [5:0] sa, sb, r;
    sa = {{2{a[3]}}, a};
    sb = {{2{b[3]}}, b};
    case (sel[2:0])
      3'd0:    r = sa + 6'sd1;
      3'd1:    r = sa - 6'sd1;
      3'd2:    r = sb + 6'sd1;
      3'd3:    r = sb - 6'sd1;
      3'd4:    r = sa - sb;
      3'd5:    r = sb - sa;
      3'd6:    r = sa + sb;
      default: r = sa + sb + 6'sd1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] alu_logic(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] sel);
    case (sel[2:0])
      3'd0:    return ~a;
      3'd1:    return ~b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a & b);
      3'd6:    return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // Expected response for a command.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] sel);
    exp_t e;
    logic signed [5:0] y;
    int v;
    if (sel[3]) begin
      e.data     = {2'b00, alu_logic(a, b, sel)};
      e.is_logic = 1'b1;
      e.ovf      = 1'b0;
    end else begin
      y          = alu_arith(a, b, sel);
      v          = y;
      e.data     = y;
      e.is_logic = 1'b0;
      e.ovf      = (v > 7) || (v < -8);
    end
    return e;
  endfunction

  assign alu1_y_a = alu_arith(alu1_a, alu1_b, alu1_sel);
  assign alu1_y_l = alu_logic(alu1_a, alu1_b, alu1_sel);
  assign alu3_y_a = alu_arith(alu3_a, alu3_b, alu3_sel);
  assign alu3_y_l = alu_logic(alu3_a, alu3_b, alu3_sel);

  alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus1),
    .alu_a    (alu1_a),
    .alu_b    (alu1_b),
    .alu_sel  (alu1_sel),
    .alu_y_a  (alu1_y_a),
    .alu_y_l  (alu1_y_l),
    .op_count (op1_count)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst3_n),
    .bus      (bus3),
    .alu_a    (alu3_a),
    .alu_b    (alu3_b),
    .alu_sel  (alu3_sel),
    .alu_y_a  (alu3_y_a),
    .alu_y_l  (alu3_y_l),
    .op_count (op3_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one command on the settle-1 instance and score its response.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    int   n;
    exp_t e;
    n = 0;
    while (bus1.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus1.cmd_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", bus1.cmd_ready, n);
    end
    bus1.cmd_valid = 1'b1;
    bus1.cmd_a     = a;
    bus1.cmd_b     = b;
    bus1.cmd_sel   = sel;
    @(posedge clk);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    bus1.cmd_a     = ~a;
    bus1.cmd_b     = ~b;
    bus1.cmd_sel   = ~sel;
    n = 0;
    while (bus1.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 1) begin
      n_err++;
      $display("FAIL rsp_latency: got %0d edges after accept, required 1", n);
    end
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: no expectation queued, required 1");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    n_cmp++;
    if (bus1.rsp_data !== e.data) begin
      n_err++;
      $display("FAIL rsp_data a=%h b=%h sel=%h: got %b, required %b", a, b, sel, bus1.rsp_data, e.data);
    end
    n_cmp++;
    if (bus1.rsp_is_logic !== e.is_logic) begin
      n_err++;
      $display("FAIL rsp_is_logic sel=%h: got %b, required %b", sel, bus1.rsp_is_logic, e.is_logic);
    end
    n_cmp++;
    if (bus1.rsp_ovf !== e.ovf) begin
      n_err++;
      $display("FAIL rsp_ovf a=%h b=%h sel=%h: got %b, required %b", a, b, sel, bus1.rsp_ovf, e.ovf);
    end
    @(negedge clk);
    cnt1 = cnt1 + 8'd1;
    n_cmp++;
    if (op1_count !== cnt1 || bus1.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL op_count_after_rsp: got count=%0d valid=%b, required count=%0d valid=0",
               op1_count, bus1.rsp_valid, cnt1);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus1.cmd_ready, alu1_a, alu1_b, alu1_sel, bus1.rsp_valid, bus1.rsp_data,
         bus1.rsp_is_logic, bus1.rsp_ovf, op1_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b a=%h b=%h sel=%h v=%b d=%h l=%b o=%b cnt=%0d, required all 0",
               bus1.cmd_ready, alu1_a, alu1_b, alu1_sel, bus1.rsp_valid, bus1.rsp_data,
               bus1.rsp_is_logic, bus1.rsp_ovf, op1_count);
    end
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    #1;
    n_cmp++;
    if (bus1.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL cmd_ready_before_edge: got %b, required 0", bus1.cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus1.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_ready_after_release: got %b, required 1", bus1.cmd_ready);
    end
    cnt1 = 8'd0;
  endtask

  task automatic test_back_to_back;
    int t0;
    logic [3:0] a, b, s;
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      exp_q.push_back(model(a, b, s));
      run_op(a, b, s);
    end
    n_cmp++;
    if (cyc - t0 != 256 * 3) begin
      n_err++;
      $display("FAIL b2b_period: got %0d cycles for 256 ops, required %0d", cyc - t0, 256 * 3);
    end
    n_cmp++;
    if (op1_count !== 8'd0) begin
      n_err++;
      $display("FAIL op_count_wrap: got %0d, required 0", op1_count);
    end
  endtask

  task automatic test_arith;
    exp_q.push_back('{data: 6'b000101, is_logic: 1'b0, ovf: 1'b0});
    run_op(4'd3, 4'd2, 4'b0110);
    exp_q.push_back('{data: 6'b001000, is_logic: 1'b0, ovf: 1'b1});
    run_op(4'd7, 4'd0, 4'b0000);
    exp_q.push_back('{data: 6'b110111, is_logic: 1'b0, ovf: 1'b1});
    run_op(4'b1000, 4'd0, 4'b0001);
    exp_q.push_back('{data: 6'b111001, is_logic: 1'b0, ovf: 1'b0});
    run_op(4'b1000, 4'd0, 4'b0000);
    exp_q.push_back('{data: 6'b000110, is_logic: 1'b0, ovf: 1'b0});
    run_op(4'd7, 4'd0, 4'b0001);
    exp_q.push_back('{data: 6'b110001, is_logic: 1'b0, ovf: 1'b1});
    run_op(4'b1000, 4'd7, 4'b0100);
    exp_q.push_back('{data: 6'b001110, is_logic: 1'b0, ovf: 1'b1});
    run_op(4'd7, 4'd7, 4'b0110);
    exp_q.push_back('{data: 6'b111101, is_logic: 1'b0, ovf: 1'b0});
    run_op(4'd2, 4'd5, 4'b0100);
  endtask

  task automatic test_logic;
    exp_q.push_back('{data: 6'b001000, is_logic: 1'b1, ovf: 1'b0});
    run_op(4'b1100, 4'b1010, 4'b1010);
    exp_q.push_back('{data: 6'b001100, is_logic: 1'b1, ovf: 1'b0});
    run_op(4'b0011, 4'b0000, 4'b1000);
    exp_q.push_back('{data: 6'b000110, is_logic: 1'b1, ovf: 1'b0});
    run_op(4'b1100, 4'b1010, 4'b1100);
    exp_q.push_back('{data: 6'b001000, is_logic: 1'b1, ovf: 1'b0});
    run_op(4'd7, 4'd7, 4'b1110);
  endtask

  task automatic test_backpressure;
    int   n;
    exp_t e;
    e = '{data: 6'b001000, is_logic: 1'b0, ovf: 1'b1};
    bus1.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_a     = 4'd5;
    bus1.cmd_b     = 4'b1101;
    bus1.cmd_sel   = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    n = 0;
    while (bus1.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      bus1.cmd_valid = (i == 1 || i == 2);
      bus1.cmd_a     = 4'd1;
      bus1.cmd_b     = 4'd1;
      bus1.cmd_sel   = 4'b1000;
      @(negedge clk);
      n_cmp++;
      if ({bus1.rsp_valid, bus1.rsp_data, bus1.rsp_is_logic, bus1.rsp_ovf, bus1.cmd_ready,
           alu1_a, alu1_b, alu1_sel} !== {1'b1, e.data, e.is_logic, e.ovf, 1'b0,
           4'd5, 4'b1101, 4'b0100}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got v=%b d=%b l=%b o=%b rdy=%b a=%h b=%h sel=%h, required v=1 d=%b l=%b o=%b rdy=0 a=5 b=d sel=4",
                 i, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_is_logic, bus1.rsp_ovf,
                 bus1.cmd_ready, alu1_a, alu1_b, alu1_sel, e.data, e.is_logic, e.ovf);
      end
    end
    bus1.cmd_valid = 1'b0;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    cnt1 = cnt1 + 8'd1;
    n_cmp++;
    if (op1_count !== cnt1 || bus1.rsp_valid !== 1'b0 || bus1.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release: got cnt=%0d v=%b rdy=%b, required cnt=%0d v=0 rdy=1",
               op1_count, bus1.rsp_valid, bus1.cmd_ready, cnt1);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus1.rsp_valid !== 1'b0 || op1_count !== cnt1 || alu1_a !== 4'd5 || alu1_sel !== 4'b0100) begin
      n_err++;
      $display("FAIL extra_cmd_ignored: got v=%b cnt=%0d a=%h sel=%h, required v=0 cnt=%0d a=5 sel=4",
               bus1.rsp_valid, op1_count, alu1_a, alu1_sel, cnt1);
    end
  endtask

  task automatic test_settle3_reset;
    int n;
    bit seen;
    // One normal operation to confirm the longer settle latency.
    n = 0;
    while (bus3.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus3.cmd_valid = 1'b1;
    bus3.cmd_a     = 4'd3;
    bus3.cmd_b     = 4'd2;
    bus3.cmd_sel   = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    n = 0;
    while (bus3.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 3 || bus3.rsp_data !== 6'b000101) begin
      n_err++;
      $display("FAIL settle3_op: got latency=%0d data=%b, required latency=3 data=000101",
               n, bus3.rsp_data);
    end
    @(negedge clk);
    n_cmp++;
    if (op3_count !== 8'd1) begin
      n_err++;
      $display("FAIL settle3_count: got %0d, required 1", op3_count);
    end
    // Second operation is killed by reset while still settling.
    bus3.cmd_valid = 1'b1;
    bus3.cmd_a     = 4'd5;
    bus3.cmd_b     = 4'd1;
    bus3.cmd_sel   = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst3_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus3.cmd_ready, alu3_a, alu3_b, alu3_sel, bus3.rsp_valid, bus3.rsp_data,
         bus3.rsp_is_logic, bus3.rsp_ovf, op3_count} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got rdy=%b a=%h b=%h sel=%h v=%b d=%h cnt=%0d, required all 0",
               bus3.cmd_ready, alu3_a, alu3_b, alu3_sel, bus3.rsp_valid, bus3.rsp_data, op3_count);
    end
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    #1;
    n_cmp++;
    if (bus3.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset3_ready_early: got %b, required 0", bus3.cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus3.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset3_ready: got %b, required 1", bus3.cmd_ready);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus3.rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen || op3_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset3_no_rsp: got rsp_seen=%b cnt=%0d, required 0 and 0", seen, op3_count);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    cnt1  = 8'd0;
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_sel = '0;
    bus1.rsp_ready = 1'b1;
    bus3.cmd_valid = 1'b0; bus3.cmd_a = '0; bus3.cmd_b = '0; bus3.cmd_sel = '0;
    bus3.rsp_ready = 1'b1;

    test_reset();
    test_back_to_back();
    test_arith();
    test_logic();
    test_backpressure();
    test_settle3_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
